// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART transmitter slice: transmit FSM state
//   encoding, frame geometry and line levels.
//   Optional feature macro: UART_TX_PARITY_EN (adds a PARITY state, 8E1 frames).
//   In the default build the PARITY encoding exists but is never entered.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam int   BIT_CNT_W   = $clog2(DATA_BITS);
  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Small synchronous FIFO buffering bytes between the CPU store port and the
//   serial shifter. Pointers carry one extra wrap bit so that full and empty
//   are distinguished by comparing the MSBs; pointers wrap naturally.
//   Read data is presented combinationally from the head entry.
//   Ports:
//     clk      in   system clock
//     rst      in   asynchronous active-low reset (empties the FIFO)
//     i_push   in   write i_data at the tail (ignored while full)
//     i_data   in   WIDTH-bit write data
//     i_pop    in   discard the head entry (ignored while empty)
//     o_data   out  head entry
//     o_full   out  all DEPTH entries occupied (from registered pointers)
//     o_empty  out  no entries (from registered pointers)
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;

  // Same index with different wrap bits means the writer has lapped the reader.
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_push_ok = i_push && !w_full;
  assign w_pop_ok  = i_pop && !w_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
//   Serialises bytes from the CPU's memory-mapped UART data register onto
//   FPGA_SERIAL_TX. Default frame is 8N1 (start, 8 data bits LSB first, stop).
//   A small FIFO decouples CPU stores from the line rate.
//   Optional feature macro: UART_TX_PARITY_EN -- when defined, an even parity
//   bit follows the data bits (8E1, 11-bit frame).
//   Handshake: a byte transfers on every rising edge where data_in_valid and
//   data_in_ready are both high; data_in_ready depends only on registered
//   FIFO state (never on data_in_valid), and a producer keeps data_in stable
//   while valid is high and ready is low.
//   Ports:
//     clk            in   system clock, rising edge
//     rst            in   asynchronous active-low reset
//     data_in        in   byte to transmit
//     data_in_valid  in   producer offers data_in
//     data_in_ready  out  FIFO not full
//     serial_out     out  UART line, idles high, driven from a flop
//     tx_busy        out  FIFO non-empty or frame in flight (registered)
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic                 serial_out,
  output logic                 tx_busy
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int BAUD_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_BITS - 1);

  // State and datapath registers
  tx_state_e             r_state;
  logic [BAUD_W-1:0]     r_baud_cnt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_serial;
  logic                  r_busy;

  // Next-state / control wires
  tx_state_e             w_next_state;
  logic [BIT_CNT_W-1:0]  w_bit_cnt_nxt;
  logic [DATA_BITS-1:0]  w_shift_nxt;
  logic                  w_serial_nxt;
  logic                  w_busy_nxt;
  logic                  w_symbol_end;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [DATA_BITS-1:0]  w_fifo_data;

`ifdef UART_TX_PARITY_EN
  logic                  r_parity;
  logic                  w_parity_nxt;
`endif

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  assign w_push = data_in_valid && !w_fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (data_in),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign w_symbol_end = (r_baud_cnt == BAUD_LAST);

  // ---------------------------------------------------------------------------
  // FSM next-state, pop and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state  = r_state;
    w_pop         = 1'b0;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;

    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_fifo_data;
          w_bit_cnt_nxt = '0;
          w_next_state  = START;
        end
      end

      START: begin
        if (w_symbol_end) w_next_state = DATA;
      end

      DATA: begin
        if (w_symbol_end) begin
          w_shift_nxt = {1'b0, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_cnt_nxt = '0;
`ifdef UART_TX_PARITY_EN
            w_next_state  = PARITY;
`else
            w_next_state  = STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (w_symbol_end) w_next_state = STOP;
      end
`endif

      STOP: begin
        if (w_symbol_end) begin
          // Chain straight into the next frame when a byte is waiting.
          if (!w_fifo_empty) begin
            w_pop         = 1'b1;
            w_shift_nxt   = w_fifo_data;
            w_bit_cnt_nxt = '0;
            w_next_state  = START;
          end else begin
            w_next_state  = IDLE;
          end
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Line level for the state being entered, so serial_out comes from a flop.
  always_comb begin
    w_serial_nxt = IDLE_LEVEL;
    case (w_next_state)
      START:   w_serial_nxt = START_LEVEL;
      DATA:    w_serial_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  w_serial_nxt = r_parity;
`endif
      default: w_serial_nxt = IDLE_LEVEL;
    endcase
  end

  // A pop never coincides with entering IDLE, so when the FSM heads to IDLE
  // the FIFO is empty afterwards exactly when it is empty now and no push lands.
  assign w_busy_nxt = (w_next_state != IDLE) || !w_fifo_empty || w_push;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_serial   <= IDLE_LEVEL;
      r_busy     <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_serial  <= w_serial_nxt;
      r_busy    <= w_busy_nxt;
      // Symbol timer restarts on every state change and at each bit boundary;
      // it is held at zero while idle.
      if ((w_next_state != r_state) || w_symbol_end || (r_state == IDLE)) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity is captured at load time because the shift register is consumed
  // by the time the parity bit goes out.
  assign w_parity_nxt = w_pop ? ^w_fifo_data : r_parity;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_parity <= 1'b0;
    end else begin
      r_parity <= w_parity_nxt;
    end
  end
`endif

  assign data_in_ready = !w_fifo_full;
  assign serial_out    = r_serial;
  assign tx_busy       = r_busy;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
//   Directed + randomized bench for uart_transmitter (CLOCK_FREQ=1000,
//   BAUD_RATE=100 -> 10 cycles per bit, FIFO_DEPTH=4).
//   The reference is a timeline model: a queue of pending bytes plus the
//   start cycle of the frame on the line; the expected line level, ready and
//   busy follow from that with plain arithmetic. A separate line decoder
//   samples mid-bit and checks bytes against the push order.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

  localparam int SET   = 10;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = SET * FRAME_BITS;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic       serial_out;
  logic       tx_busy;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .serial_out    (serial_out),
    .tx_busy       (tx_busy)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int         n_checks = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         frame_start = 0;
  int         frame_end   = 0;
  logic [7:0] cur_byte = 8'h00;
  logic [7:0] exp_q[$];
  logic [7:0] dec_q[$];
  bit         dec_active = 1'b0;
  int         dec_t0 = 0;
  logic [7:0] dec_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Level of bit idx in a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    dec_q.delete();
    frame_start = 0;
    frame_end   = 0;
    dec_active  = 1'b0;
  endtask

  task automatic check_outputs();
    logic exp_serial;
    int   k;
    int   idx;
    exp_serial = (cyc < frame_end) ? frame_bit(cur_byte, (cyc - frame_start) / SET) : 1'b1;
    chk("serial_out", 32'(serial_out), 32'(exp_serial));
    chk("data_in_ready", 32'(data_in_ready), 32'(exp_q.size() < DEPTH));
    chk("tx_busy", 32'(tx_busy), 32'((cyc < frame_end) || (exp_q.size() > 0)));
    // Independent mid-bit decoder
    if (!dec_active) begin
      if (serial_out === 1'b0) begin
        dec_active = 1'b1;
        dec_t0     = cyc;
        dec_byte   = 8'h00;
      end
    end else begin
      k = cyc - dec_t0;
      if (k % SET == SET / 2) begin
        idx = k / SET;
        if (idx >= 1 && idx <= 8) dec_byte[idx-1] = serial_out;
`ifdef UART_TX_PARITY_EN
        if (idx == 9) chk("dec_parity", 32'(serial_out), 32'(^dec_byte));
`endif
        if (idx == FRAME_BITS - 1) begin
          chk("dec_stop", 32'(serial_out), 32'd1);
          if (dec_q.size() > 0) chk("dec_byte", 32'(dec_byte), 32'(dec_q.pop_front()));
          else                  chk("dec_byte_unexpected", 32'(dec_byte), 32'hFFFF_FFFF);
          dec_active = 1'b0;
        end
      end
    end
  endtask

  // One clock: predict the transfer, advance the model at the edge, check #1 later.
  task automatic tick(output bit pushed);
    bit do_push;
    do_push = data_in_valid && rst && (exp_q.size() < DEPTH);
    @(posedge clk);
    cyc++;
    if (!rst) begin
      model_reset();
    end else begin
      // The line frees up at frame_end; the FIFO is sampled before this edge's push.
      if (cyc >= frame_end && exp_q.size() > 0) begin
        cur_byte    = exp_q.pop_front();
        frame_start = cyc;
        frame_end   = cyc + FRAME_CYC;
      end
      if (do_push) begin
        exp_q.push_back(data_in);
        dec_q.push_back(data_in);
      end
    end
    pushed = do_push;
    #1;
    check_outputs();
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle(input int n);
    bit p;
    for (int i = 0; i < n; i++) tick(p);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit keep_valid);
    bit acc;
    acc = 1'b0;
    data_in       = b;
    data_in_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) tick(acc);
    chk("accept", 32'(acc), 32'd1);
    if (!keep_valid) data_in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && (cyc < frame_end || exp_q.size() > 0); i++) idle(1);
    idle(3);
    chk("drain_busy", 32'(tx_busy), 32'd0);
    chk("drain_decoded", 32'(dec_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int n0;
    model_reset();

    // Reset held for 3 cycles, then 50 idle cycles
    idle(3);
    chk("reset_serial", 32'(serial_out), 32'd1);
    chk("reset_ready", 32'(data_in_ready), 32'd1);
    chk("reset_busy", 32'(tx_busy), 32'd0);
    rst = 1'b1;
    idle(50);

    // Single byte 0xA5: start bit right after the pop edge, busy falls at N+101
    send_byte(8'hA5, 1'b0);
    n0 = cyc;
    chk("a5_line_before_pop", 32'(serial_out), 32'd1);
    idle(1);
    chk("a5_start_latency", 32'(serial_out), 32'd0);
    idle(FRAME_CYC - 1);
    chk("a5_busy_last_cycle", 32'(tx_busy), 32'd1);
    idle(1);
    chk("a5_busy_fall_cycle", 32'(cyc - n0), 32'(FRAME_CYC + 1));
    chk("a5_busy_fall", 32'(tx_busy), 32'd0);
    drain();

    // Burst 0x00..0x04 with valid held: the first byte leaves the FIFO on the
    // next edge, so after all five the FIFO holds four and ready drops.
    for (int b = 0; b < 5; b++) send_byte(8'(b), 1'b1);
    data_in_valid = 1'b0;
    chk("burst_full_ready", 32'(data_in_ready), 32'd0);
    drain();

    // Reset pulse in the middle of 0x3C's data bits (line low on data bit 0)
    send_byte(8'h3C, 1'b0);
    idle(15);
    chk("pre_reset_line", 32'(serial_out), 32'd0);
    #3;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_reset_serial", 32'(serial_out), 32'd1);
    chk("async_reset_ready", 32'(data_in_ready), 32'd1);
    chk("async_reset_busy", 32'(tx_busy), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(50);

    // Push while full with a pop on the same edge
    send_byte(8'h11, 1'b0);
    n0 = cyc;
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
    chk("full_ready_low", 32'(data_in_ready), 32'd0);
    send_byte(8'h5A, 1'b0);
    chk("full_pop_accept_cycle", 32'(cyc - n0), 32'(FRAME_CYC + 2));
    drain();

    // Parity patterns (plain 8N1 frames in the default build)
    send_byte(8'h07, 1'b0);
    send_byte(8'h03, 1'b0);
    drain();

    // Randomized bytes and gaps
    for (int i = 0; i < 12; i++) begin
      send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 2) == 0) begin
        data_in_valid = 1'b0;
        idle($urandom_range(0, 150));
      end
    end
    data_in_valid = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
